// File: rtl/burst_memory_responder_pkg.sv
// Shared types and constants for the burst memory responder.
// Pure definitions: no latency, no flow control.
package burst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } burst_state_t;

  localparam int BEATS            = 4;
  localparam int BEAT_WIDTH       = 64;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int BEAT_IDX_WIDTH   = $clog2(BEATS);

endpackage

// File: rtl/burst_memory_responder_if.sv
// Request/beat bundle between a line initiator (master) and the memory responder (slave).
// Levels only: requests stay high for the whole transaction, beats are strobed by resp_o.
interface burst_memory_responder_if;
  import burst_mem_pkg::*;

  logic [31:0]           address_i;
  logic                  read_i;
  logic                  write_i;
  logic [BEAT_WIDTH-1:0] burst_i;
  logic [BEAT_WIDTH-1:0] burst_o;
  logic                  resp_o;

  modport master (
    output address_i, read_i, write_i, burst_i,
    input  burst_o, resp_o
  );

  modport slave (
    input  address_i, read_i, write_i, burst_i,
    output burst_o, resp_o
  );
endinterface

// File: rtl/burst_memory_responder_array.sv
// Beat-wide line storage addressed by {line, beat}; async read, sync write.
// Read is combinational, write lands on the clock edge; never stalls.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int LINE_IDX_WIDTH = 8
) (
  input  logic                                     clk,
  input  logic                                     we,
  input  logic [LINE_IDX_WIDTH+BEAT_IDX_WIDTH-1:0] addr,
  input  logic [BEAT_WIDTH-1:0]                    wdata,
  output logic [BEAT_WIDTH-1:0]                    rdata
);

  localparam int DEPTH = BEATS << LINE_IDX_WIDTH;

  // Deliberately no reset: contents must survive a reset of the FSM.
  logic [BEAT_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/burst_memory_responder.sv
// Main-memory stand-in: accepts a line read/write, waits LATENCY cycles, then moves 4 x 64-bit beats.
// Beats in cycles T+1+LATENCY..T+4+LATENCY; no backpressure, dropping the request aborts.
module burst_memory_responder
  import burst_mem_pkg::*;
#(
  parameter int LINE_IDX_WIDTH = 8,
  parameter int LATENCY        = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  burst_memory_responder_if.slave  bus
);

  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  burst_state_t              state;
  logic [CNT_W-1:0]          lat_cnt;
  logic [BEAT_IDX_WIDTH-1:0] beat;
  logic                      op_read;
  logic [LINE_IDX_WIDTH-1:0] line;

  logic                  req_held;
  logic                  mem_we;
  logic [BEAT_WIDTH-1:0] mem_rdata;

  assign req_held = op_read ? bus.read_i : bus.write_i;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
      beat    <= '0;
      op_read <= 1'b0;
      line    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.read_i || bus.write_i) begin
            op_read <= bus.read_i;
            line    <= bus.address_i[LINE_OFFSET_BITS +: LINE_IDX_WIDTH];
            beat    <= '0;
            if (LATENCY == 0) begin
              state <= BURST;
            end else begin
              state   <= WAIT;
              lat_cnt <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (!req_held) begin
            state <= IDLE;
          end else if (lat_cnt == '0) begin
            state <= BURST;
            beat  <= '0;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        BURST: begin
          // An aborted burst and a completed one both return to IDLE.
          if (!req_held || beat == BEAT_IDX_WIDTH'(BEATS - 1)) begin
            state <= IDLE;
            beat  <= '0;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write only while the initiator still holds write_i, so an abort commits nothing further.
  assign mem_we = (state == BURST) && !op_read && bus.write_i;

  burst_mem_array #(
    .LINE_IDX_WIDTH(LINE_IDX_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr ({line, beat}),
    .wdata(bus.burst_i),
    .rdata(mem_rdata)
  );

  assign bus.resp_o  = (state == BURST);
  assign bus.burst_o = (state == BURST && op_read) ? mem_rdata : '0;

endmodule

// File: tb/tb_burst_memory_responder.sv
// Scoreboard bench: two responders (LATENCY 4 and 0); read beats checked by per-DUT monitors.
module tb_burst_memory_responder;
  import burst_mem_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mon_en = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  burst_memory_responder_if if0 ();
  burst_memory_responder_if if1 ();

  burst_memory_responder #(.LINE_IDX_WIDTH(8), .LATENCY(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave)
  );
  burst_memory_responder #(.LINE_IDX_WIDTH(8), .LATENCY(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave)
  );

  logic [63:0] model0 [256][4];
  logic [63:0] model1 [256][4];
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input int sel, input bit rd, input bit wr, input logic [31:0] a);
    if (sel == 0) begin
      if0.read_i = rd; if0.write_i = wr; if0.address_i = a;
    end else begin
      if1.read_i = rd; if1.write_i = wr; if1.address_i = a;
    end
  endtask

  task automatic wdat(input int sel, input logic [63:0] d);
    if (sel == 0) if0.burst_i = d;
    else if1.burst_i = d;
  endtask

  function automatic logic get_resp(input int sel);
    return (sel == 0) ? if0.resp_o : if1.resp_o;
  endfunction

  // Monitors: read beats are popped from the scoreboard; otherwise burst_o must be zero.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (if0.resp_o && if0.read_i) begin
        if (q0.size() == 0) check("dut0_unexpected_beat", 64'(if0.resp_o), 64'd0);
        else check("dut0_read_beat", if0.burst_o, q0.pop_front());
      end else begin
        check("dut0_burst_o_zero", if0.burst_o, 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (if1.resp_o && if1.read_i) begin
        if (q1.size() == 0) check("dut1_unexpected_beat", 64'(if1.resp_o), 64'd0);
        else check("dut1_read_beat", if1.burst_o, q1.pop_front());
      end else begin
        check("dut1_burst_o_zero", if1.burst_o, 64'd0);
      end
    end
  end

  // abort_after = 3 means a full transaction; otherwise the request drops in beat abort_after+1.
  task automatic xact(input int sel, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                      input logic [63:0] d3, input int abort_after);
    int lat;
    int b;
    logic [7:0] ln;
    logic [63:0] wd [4];
    lat = (sel == 0) ? 4 : 0;
    ln = addr[5 +: 8];
    wd[0] = d0; wd[1] = d1; wd[2] = d2; wd[3] = d3;
    for (int i = 0; i < 4; i++) begin
      if (i <= abort_after) begin
        if (rd) begin
          if (sel == 0) q0.push_back(model0[ln][i]);
          else q1.push_back(model1[ln][i]);
        end else if (wr) begin
          if (sel == 0) model0[ln][i] = wd[i];
          else model1[ln][i] = wd[i];
        end
      end
    end
    @(posedge clk); #1;
    drive(sel, rd, wr, addr);
    for (int k = 0; k < 5 + lat; k++) begin
      b = k - 1 - lat;
      if (b >= 0 && b < 4) wdat(sel, wd[b]);
      if (abort_after < 3 && b == abort_after + 1) drive(sel, 1'b0, 1'b0, addr);
      @(negedge clk);
      if (!(abort_after < 3 && b == abort_after + 1))
        check("resp_o_timing", 64'(get_resp(sel)),
              64'((b >= 0 && b < 4 && b <= abort_after) ? 1 : 0));
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, 1'b0, 32'h0);
    wdat(sel, 64'h0);
    @(negedge clk);
    check("resp_o_after_done", 64'(get_resp(sel)), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0);
    wdat(0, 64'h0);
    wdat(1, 64'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_resp0", 64'(if0.resp_o), 64'd0);
    check("reset_resp1", 64'(if1.resp_o), 64'd0);
    check("reset_state0", 64'(dut0.state), 64'(IDLE));
    check("reset_state1", 64'(dut1.state), 64'(IDLE));

    // Write then read line at 0x40, also through the offset-aliased 0x5F.
    xact(0, 0, 1, 32'h40, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
         64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 3);
    xact(0, 1, 0, 32'h40, 64'h0, 64'h0, 64'h0, 64'h0, 3);
    xact(0, 1, 0, 32'h5F, 64'h0, 64'h0, 64'h0, 64'h0, 3);

    // Read and write together at 0x80: read wins, line untouched.
    xact(0, 0, 1, 32'h80, 64'hA0A0_0000_0000_0001, 64'hA0A0_0000_0000_0002,
         64'hA0A0_0000_0000_0003, 64'hA0A0_0000_0000_0004, 3);
    xact(0, 1, 1, 32'h80, 64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF,
         64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF, 3);
    xact(0, 1, 0, 32'h80, 64'h0, 64'h0, 64'h0, 64'h0, 3);

    // Abort a write after beat 1: beats 2 and 3 keep the old line data.
    xact(0, 0, 1, 32'h40, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
         64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 1);
    repeat (3) begin
      @(negedge clk);
      check("resp_o_after_abort", 64'(if0.resp_o), 64'd0);
    end
    xact(0, 1, 0, 32'h40, 64'h0, 64'h0, 64'h0, 64'h0, 3);

    // Reset while the responder sits in WAIT.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h80);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("wait_reset_resp", 64'(if0.resp_o), 64'd0);
    check("wait_reset_burst", if0.burst_o, 64'd0);
    check("wait_reset_state", 64'(dut0.state), 64'(IDLE));
    repeat (6) begin
      @(negedge clk);
      check("resp_o_after_reset", 64'(if0.resp_o), 64'd0);
    end
    xact(0, 1, 0, 32'h80, 64'h0, 64'h0, 64'h0, 64'h0, 3);
    xact(0, 1, 0, 32'h40, 64'h0, 64'h0, 64'h0, 64'h0, 3);

    // Upper address bits alias: 0x2020 lands on the same line as 0x20.
    xact(0, 0, 1, 32'h0000_0020, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
         64'h0F0F_0F0F_F0F0_F0F0, 64'hC3C3_3C3C_C3C3_3C3C, 3);
    xact(0, 1, 0, 32'h0000_2020, 64'h0, 64'h0, 64'h0, 64'h0, 3);

    // Zero latency responder: beats follow acceptance immediately.
    xact(1, 0, 1, 32'h60, 64'hBEEF_0000_0000_0000, 64'hBEEF_1111_0000_0000,
         64'hBEEF_2222_0000_0000, 64'hBEEF_3333_0000_0000, 3);
    xact(1, 1, 0, 32'h60, 64'h0, 64'h0, 64'h0, 64'h0, 3);
    repeat (3) begin
      @(negedge clk);
      check("lat0_idle_resp", 64'(if1.resp_o), 64'd0);
    end

    check("dut0_scoreboard_empty", 64'(q0.size()), 64'd0);
    check("dut1_scoreboard_empty", 64'(q1.size()), 64'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_memory_responder.md
# burst_memory_responder

Memory-side responder for the 4-beat, 64-bit burst protocol the LLC line adaptor initiates. It accepts a read or write request with a byte address, waits a programmable latency, then transfers one 256-bit line as four consecutive 64-bit beats, each marked by `resp_o`. It sits below the adaptor as a synthesizable main-memory stand-in for simulation and FPGA bring-up.

## Interface
- `LINE_IDX_WIDTH`, default 8: line index bits; storage holds 2^LINE_IDX_WIDTH 256-bit lines.
- `LATENCY`, default 4: idle cycles between request acceptance and the first beat; must be ≥ 0.
- `clk` input, 1 bit: clock.
- `reset_n` input, 1 bit: reset, synchronous, active-low.
- `address_i` input, 32 bits: byte address. Bits [4:0] are ignored. Bits [5 +: LINE_IDX_WIDTH] select the line. Higher bits are ignored, so addresses alias.
- `read_i` input, 1 bit: read request, held high for the whole transaction.
- `write_i` input, 1 bit: write request, held high for the whole transaction.
- `burst_i` input, 64 bits: write beat data, valid in each cycle in which `resp_o` is high.
- `burst_o` output, 64 bits: read beat data.
- `resp_o` output, 1 bit: beat strobe, high for exactly 4 consecutive cycles per completed transaction.

## Operation
- States:
  - IDLE.
  - WAIT: latency counter running.
  - BURST: 2-bit beat counter, 0 to 3.
- IDLE:
  - If `read_i` is high: latch op = read, latch line = `address_i[5 +: LINE_IDX_WIDTH]`.
  - Else if `write_i` is high: latch op = write and latch the line the same way.
  - Read wins when both are high.
  - After acceptance, go to WAIT with counter = LATENCY-1; if LATENCY = 0, go straight to BURST with beat = 0.
- WAIT: decrement the counter each cycle. When the counter is 0, go to BURST with beat = 0.
- BURST:
  - `resp_o` = 1.
  - Read: `burst_o` = mem[line][beat], combinational from the latched line and beat counter.
  - Write: mem[line][beat] <= `burst_i` on the clock edge.
  - Beat 0 maps to bits [63:0] of the line; beat 3 maps to bits [255:192].
  - The beat counter increments each cycle. After beat 3, go to IDLE.
- Abort: if the latched op's request line drops in WAIT or BURST, go to IDLE on the next edge. No further `resp_o` is issued. Beats already written stay committed; a beat is not written in a cycle where the request is low.
- `address_i` changes after acceptance are ignored.
- Outside BURST-read, `burst_o` = 0. Outside BURST, `resp_o` = 0.
- Reset (including mid-transaction):
  - state = IDLE, counters = 0, `resp_o` = 0, `burst_o` = 0.
  - Memory contents are not cleared and survive reset. Contents are undefined after power-up.

## Timing
- Acceptance in cycle T means beats occur in cycles T+1+LATENCY through T+4+LATENCY.
- `resp_o` is never high in the acceptance cycle.
- The earliest next acceptance is the cycle after beat 3, i.e. T+5+LATENCY, while in IDLE.
  - The adaptor drops its request in that cycle (its DONE cycle), so no spurious re-accept occurs.
  - A request still high in IDLE is a new transaction.
- Write data is sampled in the same cycle as `resp_o`. This matches an initiator that drives `burst_o` combinationally from its beat state.
- Read data is valid in the same cycle as `resp_o`. There is no registered output stage, so there is a combinational path from state to `burst_o`.
- Throughput: one line per 5+LATENCY cycles.

## Structure
- Package `burst_mem_pkg`:
  - enum `burst_state_t` with values IDLE, WAIT, BURST.
  - Constants BEATS = 4, BEAT_WIDTH = 64, LINE_OFFSET_BITS = 5.
- Sub-module `burst_mem_array`:
  - 64-bit wide, 4·2^LINE_IDX_WIDTH deep.
  - Asynchronous read, synchronous write with enable.
  - Word address = {line, beat}.
- Top level holds the FSM, the latency counter (width $clog2(LATENCY+1), minimum 1 bit), the beat counter, and the op/line latches.

## Test plan
- Write then read, LATENCY=4:
  - Write line 0x40 with beats 0x1111…, 0x2222…, 0x3333…, 0x4444…
  - Then read 0x40 (also try 0x5F).
  - Required: the same four beats in order; `resp_o` high for cycles T+5 through T+8 only.
- LATENCY=0:
  - Read accepted at T; `resp_o` high for T+1 through T+4.
  - The request deasserted at T+5 leaves the block in IDLE with no extra `resp_o`.
- Read and write both high with address 0x80:
  - Required: treated as a read; the line at 0x80 is unchanged; `burst_o` returns the stored data.
- Abort write:
  - Drop `write_i` after beat 1.
  - Required: beats 0 and 1 updated, beats 2 and 3 keep their old values, no further `resp_o`.
- Reset during WAIT:
  - Required: `resp_o`/`burst_o` = 0 on the next cycle and state = IDLE.
  - A later read of a previously written line returns the pre-reset data.
- Aliasing, LINE_IDX_WIDTH=8:
  - Write 0x0000_0020, then read 0x0000_2020.
  - Required: the same line is returned.
